vga_scan_engine: RTL and testbench

Parametrised VGA scan engine: pixel timing, down-scaled frame-buffer addressing and output alignment in one block on the 100 MHz system clock. It generates a one-in-CLK_DIV pixel enable internally, so no second clock domain is needed. It drives the read address of the single-port picture ROM/RAM and registers the returned pixel together with hsync/vsync/valid, so colour and sync stay aligned for any read latency below CLK_DIV. It also provides a per-frame tick and a frame counter for game logic.

---
 rtl/vga_scan_engine.sv | 131 +++++++++++++
 tb/tb_vga_scan_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_engine.sv
// VGA scan engine: pixel-enable divider, scan counters, scaled
// frame-buffer addressing and an aligned, registered output stage.
module vga_scan_engine #(
  parameter int CLK_DIV     = 4,
  parameter int RD_LATENCY  = 1,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int CNT_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [11:0]       pixel_in,
  output logic [11:0]       rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [CNT_W-1:0]  h_cnt,
  output logic [CNT_W-1:0]  v_cnt,
  output logic              frame_tick,
  output logic [15:0]       frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int H_S0    = H_ACTIVE + H_FP;
  localparam int H_S1    = H_S0 + H_SYNC;
  localparam int V_S0    = V_ACTIVE + V_FP;
  localparam int V_S1    = V_S0 + V_SYNC;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int PW      = ADDR_W + CNT_W;

  // Pixel data is sampled on the closing tick, so the read must land first.
  if (RD_LATENCY > CLK_DIV - 1) begin : g_bad_latency
    $error("RD_LATENCY must be below CLK_DIV");
  end

  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] hp_q;
  logic [CNT_W-1:0] vp_q;
  logic [CNT_W-1:0] h_cnt_q;
  logic [CNT_W-1:0] v_cnt_q;
  logic [11:0]      rgb_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             valid_q;
  logic             frame_tick_q;
  logic [15:0]      frame_cnt_q;

  logic tick;
  logic h_last;
  logic v_last;
  logic active;
  logic hs_win;
  logic vs_win;
  logic ft_hit;

  assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
  assign h_last = (hp_q == CNT_W'(H_TOTAL - 1));
  assign v_last = (vp_q == CNT_W'(V_TOTAL - 1));
  assign active = (hp_q < CNT_W'(H_ACTIVE))
               && (vp_q < CNT_W'(V_ACTIVE));
  assign hs_win = (hp_q >= CNT_W'(H_S0))
               && (hp_q < CNT_W'(H_S1));
  assign vs_win = (vp_q >= CNT_W'(V_S0))
               && (vp_q < CNT_W'(V_S1));
  assign ft_hit = (hp_q == '0)
               && (vp_q == CNT_W'(V_ACTIVE));

  assign pixel_addr = active
    ? ADDR_W'(PW'(vp_q >> SCALE_SHIFT) * PW'(FB_W)
              + PW'(hp_q >> SCALE_SHIFT))
    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      hp_q         <= '0;
      vp_q         <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      rgb_q        <= '0;
      valid_q      <= 1'b0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      div_q        <= tick ? '0 : div_q + DIV_W'(1);
      frame_tick_q <= 1'b0;
      if (tick) begin
        if (h_last) begin
          hp_q <= '0;
          vp_q <= v_last ? '0 : vp_q + CNT_W'(1);
        end else begin
          hp_q <= hp_q + CNT_W'(1);
        end
        h_cnt_q <= hp_q;
        v_cnt_q <= vp_q;
        valid_q <= active;
        rgb_q   <= active ? pixel_in : '0;
        hsync_q <= hs_win ? SYNC_POL : ~SYNC_POL;
        vsync_q <= vs_win ? SYNC_POL : ~SYNC_POL;
        if (ft_hit) begin
          frame_tick_q <= 1'b1;
          frame_cnt_q  <= frame_cnt_q + 16'd1;
        end
      end
    end
  end

  assign rgb        = rgb_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign valid      = valid_q;
  assign h_cnt      = h_cnt_q;
  assign v_cnt      = v_cnt_q;
  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine: two shrunken-timing instances checked every
// clock against a position-from-tick-count model.
module tb_vga_scan_engine;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vl;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        ft;
    logic [15:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [16:0] addr_a, addr_b;
  logic [11:0] pin_a = '0, pin_b = '0;
  logic [11:0] rgb_a, rgb_b;
  logic hs_a, vs_a, vl_a, ft_a;
  logic hs_b, vs_b, vl_b, ft_b;
  logic [9:0] hc_a, vc_a, hc_b, vc_b;
  logic [15:0] fc_a, fc_b;

  int e = 0;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int ft_n = 0;
  int ft_t[$];

  always #5 clk = ~clk;

  // Single-cycle-latency ROM models: data = low 12 bits of address.
  always @(posedge clk) pin_a <= addr_a[11:0];
  always @(posedge clk) pin_b <= addr_b[11:0];

  vga_scan_engine #(
    .CLK_DIV(4), .RD_LATENCY(1),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .SCALE_SHIFT(1), .ADDR_W(17), .CNT_W(10)
  ) dut_a (
    .clk(clk), .rst(rst), .pixel_addr(addr_a), .pixel_in(pin_a),
    .rgb(rgb_a), .hsync(hs_a), .vsync(vs_a), .valid(vl_a),
    .h_cnt(hc_a), .v_cnt(vc_a), .frame_tick(ft_a), .frame_cnt(fc_a)
  );

  vga_scan_engine #(
    .CLK_DIV(2), .RD_LATENCY(1),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1), .SCALE_SHIFT(0), .ADDR_W(17), .CNT_W(10)
  ) dut_b (
    .clk(clk), .rst(rst), .pixel_addr(addr_b), .pixel_in(pin_b),
    .rgb(rgb_b), .hsync(hs_b), .vsync(vs_b), .valid(vl_b),
    .h_cnt(hc_b), .v_cnt(vc_b), .frame_tick(ft_b), .frame_cnt(fc_b)
  );

  function automatic int map(int h, int v, int ss);
    if (h < HA && v < VA) return (v >> ss) * (HA >> ss) + (h >> ss);
    return 0;
  endfunction

  // e = clock edges since reset release; ticks = e / cd.
  function automatic exp_t model(int ev, int cd, int ss, bit pol);
    exp_t x;
    int n, k, ftot, p, h, v;
    ftot = HT * VT;
    n = ev / cd;
    p = n % ftot;
    x = '0;
    x.addr = 17'(map(p % HT, p / HT, ss));
    x.hs = !pol;
    x.vs = !pol;
    if (n > 0) begin
      k = n - 1;
      p = k % ftot;
      h = p % HT;
      v = p / HT;
      x.vl  = (h < HA && v < VA);
      x.rgb = x.vl ? 12'(map(h, v, ss)) : 12'd0;
      x.hs  = (h >= HA + HF && h < HA + HF + HS) ? pol : !pol;
      x.vs  = (v >= VA + VF && v < VA + VF + VS) ? pol : !pol;
      x.hc  = 10'(h);
      x.vc  = 10'(v);
      x.ft  = (ev % cd == 0) && (p == VA * HT);
      x.fc  = (k >= VA * HT) ? 16'((k - VA * HT) / ftot + 1) : 16'd0;
    end
    return x;
  endfunction

  task automatic step();
    exp_t xa, xb, oa, ob;
    @(posedge clk);
    if (rst) e = 0;
    else e++;
    cyc++;
    #1;
    xa = model(e, 4, 1, 1'b0);
    xb = model(e, 2, 0, 1'b1);
    oa = {addr_a, rgb_a, hs_a, vs_a, vl_a, hc_a, vc_a, ft_a, fc_a};
    ob = {addr_b, rgb_b, hs_b, vs_b, vl_b, hc_b, vc_b, ft_b, fc_b};
    checks++;
    assert (oa === xa) else begin
      fails++;
      $error("FAIL scan_a e=%0d got=%h exp=%h", e, oa, xa);
    end
    checks++;
    assert (ob === xb) else begin
      fails++;
      $error("FAIL scan_b e=%0d got=%h exp=%h", e, ob, xb);
    end
    if (ft_a) begin
      ft_n++;
      ft_t.push_back(cyc);
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt_h, cnt_hb, cnt_v;
    bit found;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (100 + $urandom_range(0, 400)) step();
    rst = 1'b1;
    repeat (5) step();
    rst = 1'b0;
    ft_n = 0;
    ft_t.delete();

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (vl_a && hc_a == 10'd15 && vc_a == 10'd11) found = 1'b1;
    end
    chk("find_a_last_px", int'(found), 1);
    chk("rgb_a_last_px", int'(rgb_a), 47);

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (vl_b && hc_b == 10'd15 && vc_b == 10'd11) found = 1'b1;
    end
    chk("find_b_last_px", int'(found), 1);

    while (e < 4500) step();
    chk("frame_cnt_a", int'(fc_a), 3);
    chk("frame_ticks_a", ft_n, 3);
    if (ft_t.size() == 3) begin
      chk("ft_space_1", ft_t[1] - ft_t[0], HT * VT * 4);
      chk("ft_space_2", ft_t[2] - ft_t[1], HT * VT * 4);
    end

    cnt_h = 0;
    cnt_hb = 0;
    cnt_v = 0;
    for (int i = 0; i < HT * VT * 4; i++) begin
      step();
      if (i < HT * 4 && !hs_a) cnt_h++;
      if (i < HT * 4 && hs_b) cnt_hb++;
      if (!vs_a) cnt_v++;
    end
    chk("hsync_a_low_clks", cnt_h, HS * 4);
    chk("hsync_b_high_clks", cnt_hb, HS * 2 * 2);
    chk("vsync_a_low_clks", cnt_v, VS * HT * 4);

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (vc_a == 10'd7) found = 1'b1;
    end
    chk("find_v7", int'(found), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ft_n = 0;
    while (e < 1150) step();
    chk("fc_before_vblank", int'(fc_a), 0);
    chk("ft_before_vblank", ft_n, 0);
    while (e < 1160) step();
    chk("fc_after_vblank", int'(fc_a), 1);
    chk("ft_after_vblank", ft_n, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
